// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction sequencer.
package vend_pkg;

    // Coin codes as presented by the coin acceptor.
    typedef logic [1:0] coin_t;
    localparam coin_t COIN_NICKEL  = 2'd0;
    localparam coin_t COIN_DIME    = 2'd1;
    localparam coin_t COIN_QUARTER = 2'd2;
    localparam coin_t COIN_HALF    = 2'd3;

    // Coin values in cents.
    localparam logic [7:0] VAL_NICKEL  = 8'd5;
    localparam logic [7:0] VAL_DIME    = 8'd10;
    localparam logic [7:0] VAL_QUARTER = 8'd25;
    localparam logic [7:0] VAL_HALF    = 8'd50;

    // 16-bit coin bundle {half, quarter, dime, nickel}; element index equals coin code.
    typedef logic [3:0][3:0] coin_bundle_t;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_MAKE,
        ST_PAYOUT
    } state_t;

    function automatic logic [7:0] coin_value(input coin_t code);
        case (code)
            COIN_NICKEL:  return VAL_NICKEL;
            COIN_DIME:    return VAL_DIME;
            COIN_QUARTER: return VAL_QUARTER;
            default:      return VAL_HALF;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters: single-coin deposit, bulk payout, over-draw check.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int INIT_COINS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc_valid_i,
    input  coin_t        inc_type_i,
    input  logic         sub_valid_i,
    input  coin_bundle_t sub_counts_i,
    output logic         full_o,
    output logic         overdraw_o,
    output logic [3:0]   is_there_coin_o
);

    localparam logic [3:0] INIT_CNT = 4'(INIT_COINS);

    coin_bundle_t inv_q;
    coin_bundle_t inv_d;

    // Inventory register; the counters are machine state, so they start from a known fill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inv_q <= {4{INIT_CNT}};
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values, matching hardware.
            inv_q <= inv_d;
        end
    end

    // Next inventory: deposit one coin, or remove a whole payout bundle.
    always_comb begin
        // NOTE: default first, so no path leaves inv_d unassigned and infers a latch.
        inv_d = inv_q;
        if (inc_valid_i) begin
            inv_d[inc_type_i] = inv_q[inc_type_i] + 4'd1;
        end else if (sub_valid_i) begin
            for (int i = 0; i < 4; i++) begin
                inv_d[i] = inv_q[i] - sub_counts_i[i];
            end
        end
    end

    // Status flags derived directly from the counters.
    always_comb begin
        overdraw_o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            is_there_coin_o[i] = (inv_q[i] != 4'd0);
            if (sub_counts_i[i] > inv_q[i]) begin
                overdraw_o = 1'b1;
            end
        end
        full_o = (inv_q[inc_type_i] == 4'hF);
    end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit, coin inventory, change_maker handshake, payout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int INIT_COINS = 4,
    parameter int MAX_CREDIT = 200,
    parameter int TIMEOUT    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic        select_valid,
    input  logic [7:0]  price,
    input  logic        cancel,
    output logic        cm_enable,
    output logic        cm_start,
    output logic [7:0]  change_back,
    output logic [3:0]  is_there_coin,
    input  logic        cm_done,
    input  logic [3:0]  cm_half,
    input  logic [3:0]  cm_quarter,
    input  logic [3:0]  cm_dime,
    input  logic [3:0]  cm_nickel,
    output logic [7:0]  credit,
    output logic [15:0] disp_coins,
    output logic        disp_valid,
    output logic        vend,
    output logic        coin_reject,
    output logic        error,
    output logic        busy
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]    MAX_CREDIT9 = 9'(MAX_CREDIT);

    state_t        state_q, state_d;
    logic [7:0]    credit_q, credit_d;
    logic [7:0]    change_q, change_d;
    logic          purchase_q, purchase_d;
    logic          timeout_q, timeout_d;
    logic          abort_q, abort_d;
    logic          reject_q, reject_d;
    logic [TW-1:0] timer_q, timer_d;
    coin_bundle_t  counts_q, counts_d;

    logic          launch;
    logic          inv_inc;
    logic          inv_sub;
    logic          inv_full;
    logic          overdraw;
    logic [8:0]    credit_sum;

    coin_inventory #(
        .INIT_COINS (INIT_COINS)
    ) u_inventory (
        .clock           (clock),
        .reset           (reset),
        .inc_valid_i     (inv_inc),
        .inc_type_i      (coin_type),
        .sub_valid_i     (inv_sub),
        .sub_counts_i    (counts_q),
        .full_o          (inv_full),
        .overdraw_o      (overdraw),
        .is_there_coin_o (is_there_coin)
    );

    // Ceiling check is done one bit wider so an overflowing sum cannot wrap below the limit.
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            credit_q   <= 8'd0;
            change_q   <= 8'd0;
            purchase_q <= 1'b0;
            timeout_q  <= 1'b0;
            abort_q    <= 1'b0;
            reject_q   <= 1'b0;
            timer_q    <= '0;
            counts_q   <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            purchase_q <= purchase_d;
            timeout_q  <= timeout_d;
            abort_q    <= abort_d;
            reject_q   <= reject_d;
            timer_q    <= timer_d;
            counts_q   <= counts_d;
        end
    end

    // Next-state and Moore outputs of the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        change_d   = change_q;
        purchase_d = purchase_q;
        timeout_d  = timeout_q;
        abort_d    = abort_q;
        timer_d    = timer_q;
        counts_d   = counts_q;
        reject_d   = coin_valid;   // any coin not explicitly accepted below is returned
        launch     = 1'b0;
        inv_inc    = 1'b0;
        inv_sub    = 1'b0;
        cm_enable  = 1'b0;
        cm_start   = 1'b0;
        disp_valid = 1'b0;
        vend       = 1'b0;
        error      = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_INIT: begin
                cm_enable = 1'b1;
                state_d   = ST_IDLE;
            end

            ST_IDLE: begin
                // Cancel outranks select; both outrank a coin in the same cycle.
                if (cancel && credit_q != 8'd0) begin
                    launch     = 1'b1;
                    change_d   = credit_q;
                    purchase_d = 1'b0;
                end else if (select_valid && price <= credit_q) begin
                    launch     = 1'b1;
                    change_d   = credit_q - price;
                    purchase_d = 1'b1;
                end

                if (launch) begin
                    timeout_d = 1'b0;
                    abort_d   = 1'b0;
                    timer_d   = '0;
                    counts_d  = '0;
                    state_d   = (change_d != 8'd0) ? ST_CLEAR : ST_PAYOUT;
                end else if (coin_valid && credit_sum <= MAX_CREDIT9 && !inv_full) begin
                    credit_d = credit_sum[7:0];
                    inv_inc  = 1'b1;
                    reject_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                busy      = 1'b1;
                cm_enable = 1'b1;
                timer_d   = '0;
                state_d   = abort_q ? ST_IDLE : ST_MAKE;
            end

            ST_MAKE: begin
                busy     = 1'b1;
                cm_start = 1'b1;
                if (cm_done) begin
                    // change_maker clears its counts on this edge, so take them now.
                    counts_d = {cm_half, cm_quarter, cm_dime, cm_nickel};
                    state_d  = ST_PAYOUT;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_PAYOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_PAYOUT: begin
                busy = 1'b1;
                if (timeout_q || overdraw) begin
                    error   = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    disp_valid = 1'b1;
                    vend       = purchase_q;
                    inv_sub    = 1'b1;
                    credit_d   = 8'd0;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    assign credit      = credit_q;
    assign change_back = change_q;
    assign coin_reject = reject_q;
    assign disp_coins  = disp_valid ? counts_q : 16'd0;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a behavioural change_maker per instance.
module tb_vend_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // Main instance (INIT_COINS = 4).
    logic        coin_valid = 1'b0, select_valid = 1'b0, cancel = 1'b0;
    logic [1:0]  coin_type = 2'd0;
    logic [7:0]  price = 8'd0;
    logic        cm_done = 1'b0;
    logic [3:0]  cm_half = 4'd0, cm_quarter = 4'd0, cm_dime = 4'd0, cm_nickel = 4'd0;
    logic        cm_enable, cm_start, disp_valid, vend, coin_reject, error, busy;
    logic [7:0]  change_back, credit;
    logic [3:0]  is_there_coin;
    logic [15:0] disp_coins;

    // Empty-inventory instance (INIT_COINS = 0).
    logic        coin_valid0 = 1'b0, select_valid0 = 1'b0, cancel0 = 1'b0;
    logic [1:0]  coin_type0 = 2'd0;
    logic [7:0]  price0 = 8'd0;
    logic        cm_done0 = 1'b0;
    logic [3:0]  cm_half0 = 4'd0, cm_quarter0 = 4'd0, cm_dime0 = 4'd0, cm_nickel0 = 4'd0;
    logic        cm_enable0, cm_start0, disp_valid0, vend0, coin_reject0, error0, busy0;
    logic [7:0]  change_back0, credit0;
    logic [3:0]  is_there_coin0;
    logic [15:0] disp_coins0;

    // change_maker plans: coin count to pay out, resulting bundle, or never finish.
    int          plan_n = 0, plan0_n = 0;
    logic [15:0] plan_counts = 16'd0, plan0_counts = 16'd0;
    bit          plan_hold = 1'b0, plan0_hold = 1'b1;
    int          mk_cyc = 0, mk_cyc0 = 0;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clock = ~clock;

    vend_controller dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .select_valid(select_valid), .price(price), .cancel(cancel),
        .cm_enable(cm_enable), .cm_start(cm_start), .change_back(change_back),
        .is_there_coin(is_there_coin), .cm_done(cm_done), .cm_half(cm_half),
        .cm_quarter(cm_quarter), .cm_dime(cm_dime), .cm_nickel(cm_nickel),
        .credit(credit), .disp_coins(disp_coins), .disp_valid(disp_valid), .vend(vend),
        .coin_reject(coin_reject), .error(error), .busy(busy)
    );

    vend_controller #(.INIT_COINS(0)) dut0 (
        .clock(clock), .reset(reset), .coin_valid(coin_valid0), .coin_type(coin_type0),
        .select_valid(select_valid0), .price(price0), .cancel(cancel0),
        .cm_enable(cm_enable0), .cm_start(cm_start0), .change_back(change_back0),
        .is_there_coin(is_there_coin0), .cm_done(cm_done0), .cm_half(cm_half0),
        .cm_quarter(cm_quarter0), .cm_dime(cm_dime0), .cm_nickel(cm_nickel0),
        .credit(credit0), .disp_coins(disp_coins0), .disp_valid(disp_valid0), .vend(vend0),
        .coin_reject(coin_reject0), .error(error0), .busy(busy0)
    );

    // change_maker model: one load cycle, one cycle per coin, then a one-cycle done.
    always @(posedge clock) begin
        if (cm_done) begin
            cm_done <= 1'b0;
            {cm_half, cm_quarter, cm_dime, cm_nickel} <= 16'd0;
            mk_cyc <= 0;
        end else if (!cm_start) begin
            mk_cyc <= 0;
        end else begin
            mk_cyc <= mk_cyc + 1;
            if (!plan_hold && mk_cyc == plan_n) begin
                cm_done <= 1'b1;
                {cm_half, cm_quarter, cm_dime, cm_nickel} <= plan_counts;
            end
        end
    end

    always @(posedge clock) begin
        if (cm_done0) begin
            cm_done0 <= 1'b0;
            {cm_half0, cm_quarter0, cm_dime0, cm_nickel0} <= 16'd0;
            mk_cyc0 <= 0;
        end else if (!cm_start0) begin
            mk_cyc0 <= 0;
        end else begin
            mk_cyc0 <= mk_cyc0 + 1;
            if (!plan0_hold && mk_cyc0 == plan0_n) begin
                cm_done0 <= 1'b1;
                {cm_half0, cm_quarter0, cm_dime0, cm_nickel0} <= plan0_counts;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Coin pulse on the main instance; returns one cycle later.
    task automatic insert(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        @(negedge clock);
        coin_valid = 1'b0;
    endtask

    task automatic insert0(input logic [1:0] t);
        coin_valid0 = 1'b1; coin_type0 = t;
        @(negedge clock);
        coin_valid0 = 1'b0;
    endtask

    // Waits up to limit cycles for PAYOUT (disp_valid or error); cycles counted or limit+1.
    task automatic wait_pay(input bit sel, input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock);
            if (sel ? (disp_valid0 | error0) : (disp_valid | error)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++; if (cm_enable !== 1'b1) begin errors++; $display("FAIL reset_cm_enable: got %b want 1", cm_enable); end
        checks++; if ({credit, change_back} !== 16'd0) begin errors++; $display("FAIL reset_credit_change: got %h want 0000", {credit, change_back}); end
        checks++; if ({cm_start, disp_valid, vend, coin_reject, error, busy, disp_coins} !== 22'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {cm_start, disp_valid, vend, coin_reject, error, busy, disp_coins}); end
        checks++; if ({is_there_coin, is_there_coin0} !== 8'hF0) begin errors++; $display("FAIL reset_is_there_coin: got %h want f0", {is_there_coin, is_there_coin0}); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (cm_enable !== 1'b0) begin errors++; $display("FAIL init_to_idle: cm_enable got %b want 0", cm_enable); end
    endtask

    task automatic test_purchase;
        plan_n = 2; plan_counts = 16'h0110; plan_hold = 1'b0;
        insert(2); insert(2); insert(2);
        checks++; if (credit !== 8'd75) begin errors++; $display("FAIL purchase_credit: got %0d want 75", credit); end
        select_valid = 1'b1; price = 8'd40;
        @(negedge clock);
        select_valid = 1'b0;
        checks++; if ({cm_enable, busy, change_back} !== {2'b11, 8'd35}) begin
            errors++; $display("FAIL purchase_clear: got en/busy/change %b%b/%0d want 11/35", cm_enable, busy, change_back); end
        @(negedge clock);
        checks++; if (cm_start !== 1'b1) begin errors++; $display("FAIL purchase_cm_start: got %b want 1", cm_start); end
        wait_pay(1'b0, 20, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL purchase_latency: got %0d want 4", cyc); end
        checks++; if ({disp_valid, vend, error, disp_coins} !== {3'b110, 16'h0110}) begin
            errors++; $display("FAIL purchase_payout: got %b%b%b %h want 110 0110", disp_valid, vend, error, disp_coins); end
        @(negedge clock);
        checks++; if ({credit, busy} !== 9'd0) begin errors++; $display("FAIL purchase_after: credit %0d busy %b want 0 0", credit, busy); end
        checks++; if ({dut.u_inventory.inv_q[2], dut.u_inventory.inv_q[1]} !== 8'h63) begin
            errors++; $display("FAIL purchase_inventory: got q%0d d%0d want q6 d3", dut.u_inventory.inv_q[2], dut.u_inventory.inv_q[1]); end
    endtask

    task automatic test_refund;
        plan_n = 1; plan_counts = 16'h1000;
        insert(3);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        checks++; if (change_back !== 8'd50) begin errors++; $display("FAIL refund_change: got %0d want 50", change_back); end
        wait_pay(1'b0, 20, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL refund_latency: got %0d want 4", cyc); end
        checks++; if ({disp_valid, vend, disp_coins} !== {2'b10, 16'h1000}) begin
            errors++; $display("FAIL refund_payout: got %b%b %h want 10 1000", disp_valid, vend, disp_coins); end
        @(negedge clock);
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL refund_credit: got %0d want 0", credit); end
    endtask

    task automatic test_exact_price;
        insert(1);
        select_valid = 1'b1; price = 8'd10;
        @(negedge clock);
        select_valid = 1'b0;
        checks++; if ({disp_valid, vend, busy, cm_enable, cm_start, disp_coins} !== {5'b11100, 16'h0000}) begin
            errors++; $display("FAIL exact_payout: got %b%b%b%b%b %h want 11100 0000", disp_valid, vend, busy, cm_enable, cm_start, disp_coins); end
        @(negedge clock);
        checks++; if ({credit, busy} !== 9'd0) begin errors++; $display("FAIL exact_after: credit %0d busy %b want 0 0", credit, busy); end
    endtask

    task automatic test_ceiling_full;
        insert(3); insert(3); insert(3); insert(2); insert(1); insert(0);
        checks++; if (credit !== 8'd190) begin errors++; $display("FAIL ceiling_190: got %0d want 190", credit); end
        insert(1);
        checks++; if ({coin_reject, credit} !== {1'b0, 8'd200}) begin
            errors++; $display("FAIL ceiling_200: reject %b credit %0d want 0 200", coin_reject, credit); end
        insert(0);
        checks++; if ({coin_reject, credit} !== {1'b1, 8'd200}) begin
            errors++; $display("FAIL ceiling_reject: reject %b credit %0d want 1 200", coin_reject, credit); end
        plan_n = 4; plan_counts = 16'h4000;
        cancel = 1'b1; @(negedge clock); cancel = 1'b0;
        wait_pay(1'b0, 20, cyc);
        checks++; if ({cyc, disp_coins} !== {32'd7, 16'h4000}) begin
            errors++; $display("FAIL ceiling_refund: latency %0d coins %h want 7 4000", cyc, disp_coins); end
        @(negedge clock);
        for (int i = 0; i < 10; i++) insert(0);
        checks++; if ({coin_reject, credit} !== {1'b0, 8'd50}) begin
            errors++; $display("FAIL full_fill: reject %b credit %0d want 0 50", coin_reject, credit); end
        insert(0);
        checks++; if ({coin_reject, credit} !== {1'b1, 8'd50}) begin
            errors++; $display("FAIL full_reject: reject %b credit %0d want 1 50", coin_reject, credit); end
        plan_n = 1; plan_counts = 16'h1000;
        cancel = 1'b1; @(negedge clock); cancel = 1'b0;
        wait_pay(1'b0, 20, cyc);
        @(negedge clock);
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL full_refund: credit %0d want 0", credit); end
    endtask

    task automatic test_timeout;
        insert0(2);
        checks++; if ({credit0, is_there_coin0} !== {8'd25, 4'b0100}) begin
            errors++; $display("FAIL timeout_insert: credit %0d mask %b want 25 0100", credit0, is_there_coin0); end
        select_valid0 = 1'b1; price0 = 8'd20;
        @(negedge clock);
        select_valid0 = 1'b0;
        checks++; if (change_back0 !== 8'd5) begin errors++; $display("FAIL timeout_change: got %0d want 5", change_back0); end
        wait_pay(1'b1, 40, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL timeout_latency: got %0d want 33", cyc); end
        checks++; if ({error0, vend0, disp_valid0} !== 3'b100) begin
            errors++; $display("FAIL timeout_flags: got %b%b%b want 100", error0, vend0, disp_valid0); end
        @(negedge clock);
        checks++; if ({cm_enable0, busy0} !== 2'b11) begin errors++; $display("FAIL timeout_clear: got %b%b want 11", cm_enable0, busy0); end
        @(negedge clock);
        checks++; if ({busy0, credit0} !== {1'b0, 8'd25}) begin
            errors++; $display("FAIL timeout_idle: busy %b credit %0d want 0 25", busy0, credit0); end
    endtask

    task automatic test_overdraw;
        plan0_hold = 1'b0; plan0_n = 2; plan0_counts = 16'h0200;
        insert0(3);
        select_valid0 = 1'b1; price0 = 8'd25;
        @(negedge clock);
        select_valid0 = 1'b0;
        wait_pay(1'b1, 20, cyc);
        checks++; if ({cyc, error0, vend0, disp_valid0} !== {32'd5, 3'b100}) begin
            errors++; $display("FAIL overdraw_payout: latency %0d flags %b%b%b want 5 100", cyc, error0, vend0, disp_valid0); end
        repeat (2) @(negedge clock);
        checks++; if ({busy0, credit0, is_there_coin0} !== {1'b0, 8'd75, 4'b1100}) begin
            errors++; $display("FAIL overdraw_after: busy %b credit %0d mask %b want 0 75 1100", busy0, credit0, is_there_coin0); end
    endtask

    task automatic test_coincident;
        plan_n = 1; plan_counts = 16'h0100;
        insert(2);
        select_valid = 1'b1; price = 8'd10; cancel = 1'b1;
        @(negedge clock);
        select_valid = 1'b0; cancel = 1'b0;
        checks++; if (change_back !== 8'd25) begin errors++; $display("FAIL coincident_change: got %0d want 25", change_back); end
        insert(0);
        checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL busy_coin_reject: got %b want 1", coin_reject); end
        wait_pay(1'b0, 20, cyc);
        checks++; if ({cyc, vend, disp_coins} !== {32'd3, 1'b0, 16'h0100}) begin
            errors++; $display("FAIL coincident_payout: latency %0d vend %b coins %h want 3 0 0100", cyc, vend, disp_coins); end
        @(negedge clock);
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL coincident_credit: got %0d want 0", credit); end
    endtask

    task automatic test_reset_mid_make;
        plan_hold = 1'b1;
        insert(2);
        select_valid = 1'b1; price = 8'd5;
        @(negedge clock);
        select_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if ({cm_start, busy} !== 2'b11) begin errors++; $display("FAIL mid_make: got %b%b want 11", cm_start, busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({cm_enable, cm_start, busy, credit, change_back} !== {3'b100, 16'd0}) begin
            errors++; $display("FAIL mid_reset: en %b start %b busy %b credit %0d change %0d want 1 0 0 0 0",
                               cm_enable, cm_start, busy, credit, change_back); end
        @(negedge clock);
        reset = 1'b0;
        plan_hold = 1'b0;
        @(negedge clock);
        checks++; if ({cm_enable, busy, credit} !== 10'd0) begin
            errors++; $display("FAIL mid_reset_idle: en %b busy %b credit %0d want 0 0 0", cm_enable, busy, credit); end
    endtask

    initial begin
        test_reset;
        test_purchase;
        test_refund;
        test_exact_price;
        test_ceiling_full;
        test_timeout;
        test_overdraw;
        test_coincident;
        test_reset_mid_make;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
